// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter.
//   - State encoding values and the enum built on them
//   - max_dec(): largest decimal value representable in a digit count
//   - Saturation digit values used when a result does not fit
package bcd_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_SHIFT = SHIFT,
    S_DONE  = DONE
  } state_t;

  localparam logic [3:0] SAT_DEC = 4'h9;
  localparam logic [3:0] SAT_HEX = 4'hF;

  // 10^digits - 1; 36 bits covers ten digits (9_999_999_999 < 2^34).
  function automatic logic [35:0] max_dec(input int digits);
    logic [35:0] p;
    p = 36'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 36'd10;
    end
    return p - 36'd1;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration, purely combinational.
// Ports:
//   digits_in  [4*DIGITS-1:0]  current BCD digit vector, digit 0 in [3:0]
//   bit_in                     next binary bit (MSB first) entering digit 0 bit 0
//   digits_out [4*DIGITS-1:0]  digits after add-3 correction and a left shift
module bcd_dabble_step #(
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] digits_in,
  input  logic                bit_in,
  output logic [4*DIGITS-1:0] digits_out
);

  localparam int BCD_W = 4 * DIGITS;

  logic [BCD_W-1:0] adj;

  always_comb begin
    adj = digits_in;
    for (int i = 0; i < DIGITS; i++) begin
      // A digit of 5..9 would become >= 10 after doubling; pre-add 3 so the
      // carry lands in the next digit. Max result is 9+3 = 4'hC.
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    digits_out = (adj << 1) | BCD_W'(bit_in);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter with valid/ready on both sides.
// Decimal mode runs double dabble one bit per cycle; hex mode splits the
// input into nibbles in a single step. Results that do not fit saturate
// (all 9s in decimal, all Fs in hex) and raise overflow.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready only in IDLE, not in reset
//   bin_in [IN_W-1:0]     binary value, sampled at accept
//   hex_mode              1 = nibble split, 0 = decimal; sampled at accept
//   out_valid / out_ready output handshake; out_valid only in DONE
//   bcd_out [4*DIGITS-1:0] result digits, digit 0 in [3:0]
//   overflow              result saturated
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     bin_in,
  input  logic                hex_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [IN_W-1:0]  sr_q;
  logic [BCD_W-1:0] dig_q;
  logic [BCD_W-1:0] dig_step;
  logic [BCD_W-1:0] bcd_q;
  logic             ovf_q;

  logic             accept;
  logic [35:0]      bin_ext;
  logic             dec_ovf;
  logic             hex_ovf;
  logic             ovf_now;
  logic [BCD_W-1:0] sat_val;
  logic             last_bit;

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign out_valid = (state_q == S_DONE);
  assign bcd_out   = bcd_q;
  assign overflow  = ovf_q;

  assign accept   = in_valid && in_ready;
  assign bin_ext  = 36'(bin_in);
  assign dec_ovf  = bin_ext > max_dec(DIGITS);
  assign hex_ovf  = (bin_ext >> BCD_W) != 36'd0;
  assign ovf_now  = hex_mode ? hex_ovf : dec_ovf;
  assign sat_val  = {DIGITS{hex_mode ? SAT_HEX : SAT_DEC}};
  assign last_bit = (cnt_q == CNT_W'(1));

  bcd_dabble_step #(
    .DIGITS(DIGITS)
  ) u_step (
    .digits_in (dig_q),
    .bit_in    (sr_q[IN_W-1]),
    .digits_out(dig_step)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (hex_mode || ovf_now) ? S_DONE : S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dig_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            sr_q  <= bin_in;
            dig_q <= '0;
            // Results go straight to the output only when skipping SHIFT;
            // otherwise the previous result stays visible until DONE.
            if (ovf_now) begin
              bcd_q <= sat_val;
              ovf_q <= 1'b1;
            end else if (hex_mode) begin
              bcd_q <= BCD_W'(bin_in);
              ovf_q <= 1'b0;
            end else begin
              cnt_q <= CNT_W'(IN_W);
            end
          end
        end
        S_SHIFT: begin
          sr_q  <= sr_q << 1;
          dig_q <= dig_step;
          cnt_q <= cnt_q - CNT_W'(1);
          if (last_bit) begin
            bcd_q <= dig_step;
            ovf_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance A: IN_W=8, DIGITS=3
  logic        a_in_valid, a_in_ready, a_hex, a_out_valid, a_out_ready, a_ovf;
  logic [7:0]  a_bin;
  logic [11:0] a_bcd;
  // instance B: DIGITS=2
  logic        b_in_valid, b_in_ready, b_hex, b_out_valid, b_out_ready, b_ovf;
  logic [7:0]  b_bin;
  logic [7:0]  b_bcd;
  // instance C: DIGITS=1
  logic        c_in_valid, c_in_ready, c_hex, c_out_valid, c_out_ready, c_ovf;
  logic [7:0]  c_bin;
  logic [3:0]  c_bcd;

  bin_to_bcd_seq #(.IN_W(8), .DIGITS(3)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .bin_in(a_bin), .hex_mode(a_hex), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .bcd_out(a_bcd), .overflow(a_ovf));

  bin_to_bcd_seq #(.IN_W(8), .DIGITS(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .bin_in(b_bin), .hex_mode(b_hex), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .bcd_out(b_bcd), .overflow(b_ovf));

  bin_to_bcd_seq #(.IN_W(8), .DIGITS(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .bin_in(c_bin), .hex_mode(c_hex), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .bcd_out(c_bcd), .overflow(c_ovf));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          lat;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Independent reference: repeated division for decimal, plain nibbles for hex.
  function automatic logic [40:0] model(input int unsigned v, input int d, input bit hex);
    logic [39:0] r;
    logic        o;
    longint      lim;
    int unsigned t;
    r = '0;
    o = 1'b0;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    if (hex) begin
      if ((longint'(v) >> (4 * d)) != 0) begin
        o = 1'b1;
        for (int i = 0; i < d; i++) r[4*i +: 4] = 4'hF;
      end else begin
        r = 40'(v);
      end
    end else if (longint'(v) > lim - 1) begin
      o = 1'b1;
      for (int i = 0; i < d; i++) r[4*i +: 4] = 4'h9;
    end else begin
      t = v;
      for (int i = 0; i < d; i++) begin
        r[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
    return {o, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one value into A; returns how many cycles it waited for in_ready.
  task automatic send_a(input logic [7:0] v, input bit hex, output int waits);
    logic [40:0] m;
    a_bin = v;
    a_hex = hex;
    a_in_valid = 1'b1;
    waits = 0;
    while (!a_in_ready && waits < 50) begin
      tick();
      waits++;
    end
    chk("a_accept_ready", a_in_ready, 1);
    tick();
    a_in_valid = 1'b0;
    m = model(v, 3, hex);
    sb.push_back('{bcd: m[11:0], ovf: m[40], lat: (hex || m[40]) ? 1 : 9});
  endtask

  // Wait for A's result, compare against the scoreboard, complete the
  // handshake if out_ready is high.
  task automatic recv_a();
    int   lat;
    exp_t e;
    lat = 1;
    while (!a_out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("a_out_valid_seen", a_out_valid, 1);
    if (sb.size() == 0) begin
      chk("a_scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("a_latency", 64'(lat), 64'(e.lat));
      chk("a_bcd_out", a_bcd, e.bcd);
      chk("a_overflow", a_ovf, e.ovf);
    end
    if (a_out_ready) tick();
  endtask

  // Single-shot run on B (DIGITS=2) checked directly against the model.
  task automatic run_b(input logic [7:0] v, input bit hex);
    logic [40:0] m;
    int lat;
    m = model(v, 2, hex);
    b_bin = v;
    b_hex = hex;
    b_in_valid = 1'b1;
    chk("b_in_ready", b_in_ready, 1);
    tick();
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("b_latency", 64'(lat), (hex || m[40]) ? 64'd1 : 64'd9);
    chk("b_bcd_out", b_bcd, m[7:0]);
    chk("b_overflow", b_ovf, m[40]);
    tick();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      assert (!(a_in_ready && a_out_valid)) else begin
        errors++;
        $error("FAIL a_ready_valid_exclusive: observed 1 expected 0");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waits;
    logic [7:0] rv;
    bit rh;

    reset = 1'b1;
    a_in_valid = 0; a_bin = 0; a_hex = 0; a_out_ready = 1;
    b_in_valid = 0; b_bin = 0; b_hex = 0; b_out_ready = 1;
    c_in_valid = 0; c_bin = 0; c_hex = 0; c_out_ready = 1;
    tick();
    tick();
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_bcd_out", a_bcd, 0);
    chk("rst_overflow", a_ovf, 0);
    reset = 1'b0;
    tick();
    chk("idle_in_ready", a_in_ready, 1);

    // decimal 0xAB = 171
    send_a(8'hAB, 0, waits);
    recv_a();

    // back-to-back 0 then 255
    send_a(8'd0, 0, waits);
    recv_a();
    send_a(8'hFF, 0, waits);
    chk("b2b_accept_waits", 64'(waits), 0);
    recv_a();

    // hex mode
    send_a(8'hAB, 1, waits);
    recv_a();
    send_a(8'hFF, 1, waits);
    recv_a();

    // DIGITS=2: decimal overflow, boundary 99, just above at 100
    run_b(8'd200, 0);
    run_b(8'd99, 0);
    run_b(8'd100, 0);
    run_b(8'h5A, 1);

    // DIGITS=1 hex overflow
    c_bin = 8'h12;
    c_hex = 1'b1;
    c_in_valid = 1'b1;
    chk("c_in_ready", c_in_ready, 1);
    tick();
    c_in_valid = 1'b0;
    chk("c_out_valid_lat1", c_out_valid, 1);
    chk("c_bcd_out", c_bcd, 4'hF);
    chk("c_overflow", c_ovf, 1);
    tick();

    // backpressure with ignored in_valid pulses
    a_out_ready = 1'b0;
    send_a(8'd99, 0, waits);
    recv_a();
    for (int k = 0; k < 5; k++) begin
      a_bin = 8'h55;
      a_hex = 1'b1;
      a_in_valid = (k % 2) == 0;
      tick();
      chk("bp_out_valid", a_out_valid, 1);
      chk("bp_bcd_out", a_bcd, 12'h099);
      chk("bp_overflow", a_ovf, 0);
      chk("bp_in_ready", a_in_ready, 0);
    end
    // out_ready and in_valid together: only the output side completes
    a_in_valid = 1'b1;
    a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk("hs_out_valid", a_out_valid, 0);
    chk("hs_in_ready", a_in_ready, 1);
    chk("hs_bcd_held", a_bcd, 12'h099);
    tick();
    chk("hs_no_accept", a_out_valid, 0);
    chk("hs_still_idle", a_in_ready, 1);

    // random mix
    for (int k = 0; k < 6; k++) begin
      rv = 8'($urandom_range(0, 255));
      rh = 1'($urandom_range(0, 1));
      send_a(rv, rh, waits);
      recv_a();
    end

    // reset on the 4th SHIFT cycle
    send_a(8'hFF, 0, waits);
    recv_a();
    send_a(8'hAB, 0, waits);
    tick();
    tick();
    tick();
    chk("pre_rst_in_shift", a_in_ready, 0);
    reset = 1'b1;
    tick();
    chk("abort_out_valid", a_out_valid, 0);
    chk("abort_bcd_out", a_bcd, 0);
    chk("abort_overflow", a_ovf, 0);
    chk("abort_in_ready", a_in_ready, 0);
    void'(sb.pop_back());
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", a_in_ready, 1);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("post_rst_no_valid", a_out_valid, 0);
    end
    send_a(8'd42, 0, waits);
    recv_a();
    chk("scoreboard_drained", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter that turns a received UART byte (or any `IN_W`-bit binary value) into display digits. It generalises the earlier nibble-split block in three ways: parametrised input width and digit count, a true decimal conversion mode (shift-add-3 / double dabble, one bit per cycle), and the legacy hex nibble-split mode kept as a runtime option. It uses valid/ready handshakes on both sides and sits between the UART receiver data path and the 7-segment display driver.

## Interface
- `IN_W`, 8, binary input width; legal range 1..32.
- `DIGITS`, 3, number of 4-bit output digits; legal range 1..10.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `bin_in` and `hex_mode` are valid.
- `in_ready`  out  1  block can accept a value; high only in IDLE and while `reset` is low.
- `bin_in`  in  `IN_W`  binary value to convert.
- `hex_mode`  in  1  1 selects nibble split, 0 selects decimal conversion; sampled at accept.
- `out_valid`  out  1  `bcd_out` and `overflow` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `bcd_out`  out  `4*DIGITS`  digit 0 (least significant) is in bits [3:0].
- `overflow`  out  1  the value did not fit in `DIGITS` digits; output is saturated.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid && in_ready`, capture `bin_in` into the shift register, latch `hex_mode`, and compute `ovf`.
  - Decimal overflow: `ovf` = `bin_in > 10^DIGITS-1`.
  - Hex overflow: `ovf` = any nonzero `bin_in` bit at or above position `4*DIGITS`.
  - Next state: hex mode or `ovf` → DONE; otherwise clear the digit register, load `cnt` = `IN_W`, go to SHIFT.
- **SHIFT** (one input bit per cycle):
  - Every digit ≥5 first gets +3.
  - Then shift {digits, shift reg} left by 1; the MSB of the shift register enters digit 0 bit 0.
  - `cnt` decrements; on `cnt`==1 go to DONE.
- **DONE:**
  - `out_valid` = 1; `bcd_out` and `overflow` are held stable.
  - On `out_ready`, go to IDLE.
- **Results written on entry to DONE:**
  - Hex mode: `bcd_out` = `bin_in` zero-extended or truncated to `4*DIGITS` bits.
  - Hex overflow: all digits = 4'hF.
  - Decimal overflow: all digits = 4'h9.
  - `overflow` = `ovf`.
- `bcd_out` and `overflow` keep their last value after the handshake until the next result is written.
- Arithmetic per digit is 4-bit; the +3 never exceeds 4'hC. `cnt` width is `$clog2(IN_W+1)`.
- New input is never accepted outside IDLE; `in_valid` is ignored in SHIFT and DONE.

## Timing
- **Reset values** (effective at the first edge with `reset` high):
  - State IDLE; `out_valid` 0; `bcd_out` 0; `overflow` 0; `cnt` 0.
  - `in_ready` is 0 while `reset` is high.
- **Reset mid-operation:**
  - In any state, `reset` aborts immediately and discards the captured value.
  - No `out_valid` follows for an aborted conversion.
- **Decimal latency:** accept edge T → `out_valid` high after edge T+`IN_W`+1.
  - SHIFT occupies `IN_W` cycles.
- **Hex mode or overflow latency:** `out_valid` high after edge T+1.
- **Back-to-back throughput:**
  - The output handshake at edge D returns to IDLE; next accept at D+1 at the earliest.
  - Decimal rate is one result per `IN_W`+2 cycles.
- **Backpressure:** `out_ready` low holds DONE indefinitely with outputs constant.
- **Simultaneous `out_ready` and `in_valid` in DONE:** only the output handshake completes; the input is not accepted.
- `out_valid` and `in_ready` are never high in the same cycle.

## Structure
- **Shared package `bcd_pkg`:**
  - State encoding localparams IDLE=0, SHIFT=1, DONE=2.
  - Function `max_dec(DIGITS)` returning 10^DIGITS-1, sized to 36 bits.
  - Constants for the saturation digits (4'h9, 4'hF).
- **Sub-module `bcd_dabble_step`:**
  - Combinational; parameter `DIGITS`.
  - Inputs: digit vector and incoming bit.
  - Output: adjusted-and-shifted digit vector.
  - Instantiated once in the top level.
- **Top-level contents:** FSM, counter, shift register, overflow compare and output registers.

## Test plan
- `IN_W`=8, `DIGITS`=3, decimal, `bin_in`=8'hAB → `bcd_out`=12'h171, `overflow`=0, `out_valid` 9 cycles after accept.
- Same configuration, `bin_in`=0 and then 8'hFF back-to-back with `out_ready` tied 1 → 12'h000 then 12'h255; second accept exactly 1 cycle after first output handshake.
- Hex mode, `bin_in`=8'hAB → `bcd_out`=12'h0AB, `overflow`=0, `out_valid` 1 cycle after accept.
- `DIGITS`=2, decimal, `bin_in`=200 → `bcd_out`=8'h99, `overflow`=1, latency 1; `DIGITS`=1, hex mode, 8'h12 → 4'hF, `overflow`=1.
- `bin_in`=8'd99 with `out_ready` held low 5 cycles → `out_valid` and `bcd_out`=12'h099 stable for 5 cycles; `in_ready` low throughout; `in_valid` pulses ignored.
- `reset` asserted on the 4th SHIFT cycle → next edge: state IDLE, `out_valid` 0, `bcd_out` 0; after release, 8'd42 converts to 12'h042.
